// File: rtl/axis_parity_splitter.sv
// axis_parity_splitter: AXI-Stream 1-to-2 router. Each accepted beat goes to
// the odd or even master port by a parity rule (PARITY_SEL). Each port has
// its own FIFO and its own backpressure.
// Optional statistics counters: define AXIS_PARITY_SPLITTER_STATS_EN.
module axis_parity_splitter #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_SEL = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              a_clk,
    input  logic              axis_aresetn,
    input  logic              axis_s_tvalid,
    input  logic [DATA_W-1:0] axis_s_tdata,
    input  logic              axis_s_tlast,
    output logic              axis_s_tready,
    output logic              axis_m_tvalid_odd,
    output logic [DATA_W-1:0] axis_m_tdata_odd,
    output logic              axis_m_tlast_odd,
    input  logic              axis_m_tready_odd,
    output logic              axis_m_tvalid_even,
    output logic [DATA_W-1:0] axis_m_tdata_even,
    output logic              axis_m_tlast_even,
    input  logic              axis_m_tready_even,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_beats_odd,
    output logic [CNT_W-1:0]  stat_beats_even,
    output logic [CNT_W-1:0]  stat_pkts_odd,
    output logic [CNT_W-1:0]  stat_pkts_even
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    // Channel index 0 = even port, 1 = odd port.
    logic [ENT_W-1:0] r_mem    [2][FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr [2];
    logic [PTR_W-1:0] r_rd_ptr [2];
    logic [OCC_W-1:0] r_count  [2];
    logic [OCC_W-1:0] w_count_nxt [2];
    logic [ENT_W-1:0] w_head   [2];
    logic             w_push   [2];
    logic             w_pop    [2];
    logic             w_valid  [2];
    logic             w_m_tready [2];
    logic             r_s_tready;
    logic             w_accept;
    logic             w_par;

    assign w_accept      = axis_s_tvalid & r_s_tready;
    assign axis_s_tready = r_s_tready;
    assign w_m_tready[0] = axis_m_tready_even;
    assign w_m_tready[1] = axis_m_tready_odd;

    // Parity bit selecting the destination port.
    always_comb begin
        if (PARITY_SEL == 0) begin
            w_par = ^axis_s_tdata;
        end else begin
            w_par = axis_s_tdata[0];
        end
    end

    // Per-channel push/pop decode and next occupancy.
    always_comb begin
        for (int unsigned c = 0; c < 2; c++) begin
            w_push[c]  = w_accept & (w_par == c[0]);
            w_valid[c] = (r_count[c] != '0);
            w_pop[c]   = w_valid[c] & w_m_tready[c];
            w_head[c]  = r_mem[c][r_rd_ptr[c]];
            case ({w_push[c], w_pop[c]})
                2'b10:   w_count_nxt[c] = r_count[c] + OCC_W'(1);
                2'b01:   w_count_nxt[c] = r_count[c] - OCC_W'(1);
                default: w_count_nxt[c] = r_count[c];
            endcase
        end
    end

    // FIFO pointers, occupancy and the registered input ready.
    // Ready is derived from next occupancy so it falls on the filling push
    // and stays up when a pop on that FIFO coincides with it.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            for (int unsigned c = 0; c < 2; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
            r_s_tready <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
                if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
                r_count[c] <= w_count_nxt[c];
            end
            r_s_tready <= (w_count_nxt[0] != OCC_FULL) && (w_count_nxt[1] != OCC_FULL);
        end
    end

    // FIFO storage write; contents need no reset since outputs are gated by occupancy.
    always_ff @(posedge a_clk) begin
        for (int unsigned c = 0; c < 2; c++) begin
            if (w_push[c]) r_mem[c][r_wr_ptr[c]] <= {axis_s_tdata, axis_s_tlast};
        end
    end

    // Output data/last are forced to zero while the FIFO is empty so that
    // reset (which empties the FIFOs) also clears them.
    assign axis_m_tvalid_even = w_valid[0];
    assign axis_m_tdata_even  = w_valid[0] ? w_head[0][ENT_W-1:1] : '0;
    assign axis_m_tlast_even  = w_valid[0] & w_head[0][0];
    assign axis_m_tvalid_odd  = w_valid[1];
    assign axis_m_tdata_odd   = w_valid[1] ? w_head[1][ENT_W-1:1] : '0;
    assign axis_m_tlast_odd   = w_valid[1] & w_head[1][0];

`ifdef AXIS_PARITY_SPLITTER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_beats_odd;
    logic [CNT_W-1:0] r_beats_even;
    logic [CNT_W-1:0] r_pkts_odd;
    logic [CNT_W-1:0] r_pkts_even;

    // Saturating per-port counters; clear wins over a coincident push.
    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_beats_odd  <= '0;
            r_beats_even <= '0;
            r_pkts_odd   <= '0;
            r_pkts_even  <= '0;
        end else if (stat_clr) begin
            r_beats_odd  <= '0;
            r_beats_even <= '0;
            r_pkts_odd   <= '0;
            r_pkts_even  <= '0;
        end else begin
            if (w_push[1] && r_beats_odd != CNT_MAX)
                r_beats_odd <= r_beats_odd + CNT_W'(1);
            if (w_push[0] && r_beats_even != CNT_MAX)
                r_beats_even <= r_beats_even + CNT_W'(1);
            if (w_push[1] && axis_s_tlast && r_pkts_odd != CNT_MAX)
                r_pkts_odd <= r_pkts_odd + CNT_W'(1);
            if (w_push[0] && axis_s_tlast && r_pkts_even != CNT_MAX)
                r_pkts_even <= r_pkts_even + CNT_W'(1);
        end
    end

    assign stat_beats_odd  = r_beats_odd;
    assign stat_beats_even = r_beats_even;
    assign stat_pkts_odd   = r_pkts_odd;
    assign stat_pkts_even  = r_pkts_even;
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = stat_clr;

    assign stat_beats_odd  = '0;
    assign stat_beats_even = '0;
    assign stat_pkts_odd   = '0;
    assign stat_pkts_even  = '0;
`endif

endmodule

// File: tb/tb_axis_parity_splitter.sv
// Testbench for axis_parity_splitter: table-driven routing vectors on two
// instances (PARITY_SEL=0 and PARITY_SEL=1) plus hand-written sequences for
// backpressure, ready timing, asynchronous reset and statistics.
module tb_axis_parity_splitter;

    logic       clk;
    logic       rst_n;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       m_tready_odd;
    logic       m_tready_even;
    logic       stat_clr;

    // Instance 0: PARITY_SEL=0, CNT_W=2
    logic       s_tready;
    logic       tvalid_odd, tlast_odd, tvalid_even, tlast_even;
    logic [7:0] tdata_odd, tdata_even;
    logic [1:0] beats_odd, beats_even, pkts_odd, pkts_even;

    // Instance 1: PARITY_SEL=1
    logic        p1_s_tready;
    logic        p1_tvalid_odd, p1_tlast_odd, p1_tvalid_even, p1_tlast_even;
    logic [7:0]  p1_tdata_odd, p1_tdata_even;
    logic [15:0] p1_beats_odd, p1_beats_even, p1_pkts_odd, p1_pkts_even;

    int total = 0;
    int bad   = 0;

`ifdef AXIS_PARITY_SPLITTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    axis_parity_splitter #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY_SEL(0), .CNT_W(2)) u_dut0 (
        .a_clk(clk), .axis_aresetn(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
        .axis_s_tready(s_tready),
        .axis_m_tvalid_odd(tvalid_odd), .axis_m_tdata_odd(tdata_odd),
        .axis_m_tlast_odd(tlast_odd), .axis_m_tready_odd(m_tready_odd),
        .axis_m_tvalid_even(tvalid_even), .axis_m_tdata_even(tdata_even),
        .axis_m_tlast_even(tlast_even), .axis_m_tready_even(m_tready_even),
        .stat_clr(stat_clr),
        .stat_beats_odd(beats_odd), .stat_beats_even(beats_even),
        .stat_pkts_odd(pkts_odd), .stat_pkts_even(pkts_even)
    );

    axis_parity_splitter #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY_SEL(1), .CNT_W(16)) u_dut1 (
        .a_clk(clk), .axis_aresetn(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
        .axis_s_tready(p1_s_tready),
        .axis_m_tvalid_odd(p1_tvalid_odd), .axis_m_tdata_odd(p1_tdata_odd),
        .axis_m_tlast_odd(p1_tlast_odd), .axis_m_tready_odd(m_tready_odd),
        .axis_m_tvalid_even(p1_tvalid_even), .axis_m_tdata_even(p1_tdata_even),
        .axis_m_tlast_even(p1_tlast_even), .axis_m_tready_even(m_tready_even),
        .stat_clr(stat_clr),
        .stat_beats_odd(p1_beats_odd), .stat_beats_even(p1_beats_even),
        .stat_pkts_odd(p1_pkts_odd), .stat_pkts_even(p1_pkts_even)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       odd0;   // expected port for PARITY_SEL=0
        logic       odd1;   // expected port for PARITY_SEL=1
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at a negedge; holds the beat until the DUT takes it.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (!s_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", {31'd0, s_tready}, 32'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        stat_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [7:0] stall_data[6];
    logic [7:0] rec[$];

    initial begin
        vecs[0] = '{d: 8'h03, l: 1'b0, odd0: 1'b0, odd1: 1'b1};
        vecs[1] = '{d: 8'h07, l: 1'b0, odd0: 1'b1, odd1: 1'b1};
        vecs[2] = '{d: 8'h00, l: 1'b0, odd0: 1'b0, odd1: 1'b0};
        vecs[3] = '{d: 8'hFF, l: 1'b1, odd0: 1'b0, odd1: 1'b1};
        vecs[4] = '{d: 8'h02, l: 1'b0, odd0: 1'b1, odd1: 1'b0};
        vecs[5] = '{d: 8'h05, l: 1'b1, odd0: 1'b0, odd1: 1'b1};
        vecs[6] = '{d: 8'h80, l: 1'b1, odd0: 1'b1, odd1: 1'b0};
        vecs[7] = '{d: 8'h11, l: 1'b0, odd0: 1'b0, odd1: 1'b1};
        stall_data = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

        rst_n = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        m_tready_odd = 1'b1; m_tready_even = 1'b1;
        stat_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tready", {31'd0, s_tready}, 32'd0);
        chk("rst_valid_odd", {31'd0, tvalid_odd}, 32'd0);
        chk("rst_valid_even", {31'd0, tvalid_even}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_after_release", {31'd0, s_tready}, 32'd1);
        chk("p1_tready_after_release", {31'd0, p1_s_tready}, 32'd1);
        chk("idle_valid_odd", {31'd0, tvalid_odd}, 32'd0);
        chk("idle_valid_even", {31'd0, tvalid_even}, 32'd0);
        chk("idle_beats_odd", {30'd0, beats_odd}, 32'd0);
        chk("idle_pkts_even", {30'd0, pkts_even}, 32'd0);

        // Routing table: one beat per step, visible one cycle after acceptance
        for (int i = 0; i < 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = vecs[i].d;
            s_tlast  = vecs[i].l;
            chk("tbl_tready", {31'd0, s_tready}, 32'd1);
            @(negedge clk);
            s_tvalid = 1'b0;
            chk($sformatf("tbl%0d_p0_vodd", i), {31'd0, tvalid_odd}, {31'd0, vecs[i].odd0});
            chk($sformatf("tbl%0d_p0_veven", i), {31'd0, tvalid_even}, {31'd0, !vecs[i].odd0});
            chk($sformatf("tbl%0d_p0_data", i), {24'd0, vecs[i].odd0 ? tdata_odd : tdata_even}, {24'd0, vecs[i].d});
            chk($sformatf("tbl%0d_p0_last", i), {31'd0, vecs[i].odd0 ? tlast_odd : tlast_even}, {31'd0, vecs[i].l});
            chk($sformatf("tbl%0d_p1_vodd", i), {31'd0, p1_tvalid_odd}, {31'd0, vecs[i].odd1});
            chk($sformatf("tbl%0d_p1_veven", i), {31'd0, p1_tvalid_even}, {31'd0, !vecs[i].odd1});
            chk($sformatf("tbl%0d_p1_data", i), {24'd0, vecs[i].odd1 ? p1_tdata_odd : p1_tdata_even}, {24'd0, vecs[i].d});
            chk($sformatf("tbl%0d_p1_last", i), {31'd0, vecs[i].odd1 ? p1_tlast_odd : p1_tlast_even}, {31'd0, vecs[i].l});
            @(negedge clk);
            chk($sformatf("tbl%0d_drained", i), {30'd0, tvalid_odd, tvalid_even}, 32'd0);
        end

        // Odd port stalled: 4 accepted, ready drops, head held, then all 6 in order
        do_reset();
        m_tready_odd = 1'b0;
        m_tready_even = 1'b1;
        begin
            int in_idx;
            bit acc;
            in_idx = 0;
            rec.delete();
            for (int cyc = 0; cyc < 60; cyc++) begin
                m_tready_odd = (cyc >= 10);
                if (cyc == 8) begin
                    chk("stall_tready", {31'd0, s_tready}, 32'd0);
                    chk("stall_accepted", in_idx, 32'd4);
                    chk("stall_valid", {31'd0, tvalid_odd}, 32'd1);
                    chk("stall_head", {24'd0, tdata_odd}, 32'h01);
                    chk("stall_even_idle", {31'd0, tvalid_even}, 32'd0);
                end
                if (in_idx < 6) begin
                    s_tvalid = 1'b1;
                    s_tdata  = stall_data[in_idx];
                    s_tlast  = (in_idx == 5);
                end else begin
                    s_tvalid = 1'b0;
                end
                acc = s_tvalid && s_tready;
                if (tvalid_odd && m_tready_odd) rec.push_back(tdata_odd);
                @(negedge clk);
                if (acc) in_idx++;
                if (rec.size() == 6) break;
            end
            s_tvalid = 1'b0;
            chk("stall_rx_count", rec.size(), 32'd6);
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("stall_rx%0d", k), (k < rec.size()) ? {24'd0, rec[k]} : 32'hDEAD, {24'd0, stall_data[k]});
            end
        end

        // Ready stays up when a push and pop coincide at occupancy 3; drops at 4
        do_reset();
        m_tready_odd = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h04, 1'b0);
        chk("occ3_tready", {31'd0, s_tready}, 32'd1);
        m_tready_odd = 1'b1;
        send_beat(8'h08, 1'b0);
        m_tready_odd = 1'b0;
        chk("pushpop_tready", {31'd0, s_tready}, 32'd1);
        chk("pushpop_head", {24'd0, tdata_odd}, 32'h02);
        send_beat(8'h10, 1'b0);
        chk("full_tready", {31'd0, s_tready}, 32'd0);
        chk("full_head", {24'd0, tdata_odd}, 32'h02);

        // Asynchronous reset mid-cycle with beats buffered
        do_reset();
        m_tready_odd = 1'b0;
        m_tready_even = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h03, 1'b1);
        send_beat(8'h02, 1'b0);
        chk("pre_arst_vodd", {31'd0, tvalid_odd}, 32'd1);
        chk("pre_arst_veven", {31'd0, tvalid_even}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vodd", {31'd0, tvalid_odd}, 32'd0);
        chk("arst_veven", {31'd0, tvalid_even}, 32'd0);
        chk("arst_p1_vodd", {31'd0, p1_tvalid_odd}, 32'd0);
        chk("arst_tready", {31'd0, s_tready}, 32'd0);
        chk("arst_tdata_odd", {24'd0, tdata_odd}, 32'd0);
        chk("arst_tlast_even", {31'd0, tlast_even}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_tready_odd = 1'b1;
        m_tready_even = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_arst_vodd", {31'd0, tvalid_odd}, 32'd0);
        chk("post_arst_veven", {31'd0, tvalid_even}, 32'd0);
        chk("post_arst_tready", {31'd0, s_tready}, 32'd1);

        // Statistics: 5 odd beats, 2 with tlast, CNT_W=2 saturates at 3
        do_reset();
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b1);
        send_beat(8'h04, 1'b0);
        send_beat(8'h08, 1'b1);
        send_beat(8'h10, 1'b0);
        @(negedge clk);
        chk("stat_beats_odd_sat", {30'd0, beats_odd}, STATS ? 32'd3 : 32'd0);
        chk("stat_pkts_odd", {30'd0, pkts_odd}, STATS ? 32'd2 : 32'd0);
        chk("stat_beats_even", {30'd0, beats_even}, 32'd0);
        chk("p1_stat_beats_odd", {16'd0, p1_beats_odd}, STATS ? 32'd1 : 32'd0);
        chk("p1_stat_beats_even", {16'd0, p1_beats_even}, STATS ? 32'd4 : 32'd0);
        chk("p1_stat_pkts_even", {16'd0, p1_pkts_even}, STATS ? 32'd2 : 32'd0);
        stat_clr = 1'b1;
        send_beat(8'h01, 1'b1);
        stat_clr = 1'b0;
        chk("clr_beats_odd", {30'd0, beats_odd}, 32'd0);
        chk("clr_pkts_odd", {30'd0, pkts_odd}, 32'd0);
        chk("clr_p1_beats_even", {16'd0, p1_beats_even}, 32'd0);
        send_beat(8'h03, 1'b1);
        chk("after_clr_beats_even", {30'd0, beats_even}, STATS ? 32'd1 : 32'd0);
        chk("after_clr_pkts_even", {30'd0, pkts_even}, STATS ? 32'd1 : 32'd0);
        chk("after_clr_beats_odd", {30'd0, beats_odd}, 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
